// File: rtl/instr_fetch_pkg.sv
// Shared fetch constants, the FIFO entry payload and a small alignment helper.
package instr_fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned FIFO_DEPTH = 2;

  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  function automatic logic pc_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; a pop in the flush cycle still completes.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, 2-entry {pc, instr} buffer, FETCH/HALT control.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            fetch_fault
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic            push, flush, transfer;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t    push_entry, head_entry;

  assign transfer   = if_valid & if_ready;
  assign push_entry = '{pc: pc_q, instr: rom_data};

  // A redirect always flushes and never pushes; a full buffer pushes only if the head leaves.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (pc_aligned(redirect_target[1:0])) begin
            pc_d = redirect_target;
          end else begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end
        end else if ((fifo_count < CNT_W'(FIFO_DEPTH)) || transfer) begin
          push = 1'b1;
          pc_d = pc_q + PC_INC;
        end
      end
      ST_HALT: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (transfer),
    .head_data (head_entry),
    .count     (fifo_count)
  );

  assign rom_addr    = pc_q;
  assign if_valid    = (fifo_count != '0);
  assign if_pc       = head_entry.pc;
  assign if_instr    = head_entry.instr;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic against a queue-based model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC_B = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: default RESET_PC
  logic        rst = 1'b1;
  logic [31:0] rom_addr, rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        if_valid, if_ready = 1'b0;
  logic [31:0] if_instr, if_pc;
  logic        fetch_fault;

  // instance B: wrap-around RESET_PC
  logic        rst_b = 1'b1;
  logic [31:0] rom_addr_b, rom_data_b;
  logic        redirect_valid_b = 1'b0;
  logic [31:0] redirect_target_b = 32'h0;
  logic        if_valid_b, if_ready_b = 1'b1;
  logic [31:0] if_instr_b, if_pc_b;
  logic        fetch_fault_b;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_q[$];
  logic        m_halt = 1'b0;
  logic        m_fault = 1'b0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  assign rom_data   = rom_word(rom_addr);
  assign rom_data_b = rom_word(rom_addr_b);

  instr_fetch dut_a (
    .clk             (clk),
    .rst             (rst),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .fetch_fault     (fetch_fault)
  );

  instr_fetch #(.RESET_PC(RST_PC_B)) dut_b (
    .clk             (clk),
    .rst             (rst_b),
    .rom_addr        (rom_addr_b),
    .rom_data        (rom_data_b),
    .redirect_valid  (redirect_valid_b),
    .redirect_target (redirect_target_b),
    .if_valid        (if_valid_b),
    .if_ready        (if_ready_b),
    .if_instr        (if_instr_b),
    .if_pc           (if_pc_b),
    .fetch_fault     (fetch_fault_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs to the model, then advance both across the edge.
  task automatic cycle(input logic r, input logic rdy, input logic rv, input logic [31:0] rt);
    rst = r; if_ready = rdy; redirect_valid = rv; redirect_target = rt;
    #1;
    chk("rom_addr", rom_addr, m_pc);
    chk("if_valid", 32'(if_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("if_pc", if_pc, m_q[0]);
      chk("if_instr", if_instr, rom_word(m_q[0]));
    end
    chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    if (r) begin
      m_pc = 32'h0; m_q.delete(); m_halt = 1'b0; m_fault = 1'b0;
    end else begin
      if (rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (!m_halt) begin
        if (rv) begin
          m_q.delete();
          if (rt[1:0] == 2'b00) m_pc = rt;
          else begin m_halt = 1'b1; m_fault = 1'b1; end
        end else if (m_q.size() < 2) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic        rr, rdy, rv;
    logic [31:0] rt;

    repeat (2) @(posedge clk);
    #1;

    // reset state, then free-running stream
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // stall with a full buffer, then resume
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("stall_rom_addr", rom_addr, 32'h8);
    chk("stall_head_pc", if_pc, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // aligned redirect while head waits
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("pre_redirect_head", if_pc, 32'h4);
    cycle(1'b0, 1'b0, 1'b1, 32'h1C);
    chk("redirect_bubble", 32'(if_valid), 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // misaligned redirect halts; later redirect ignored; reset recovers
    cycle(1'b0, 1'b1, 1'b1, 32'h1E);
    chk("fault_set", 32'(fetch_fault), 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // reset wins over a full buffer and a redirect
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h40);
    chk("rst_over_redirect_pc", rom_addr, 32'h0);
    chk("rst_over_redirect_valid", 32'(if_valid), 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rt  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 0) rt = rt & 32'h0000_00FC;
      if (rv && $urandom_range(0, 19) == 0) rt = rt | 32'(($urandom_range(1, 3)));
      rr  = (m_halt && $urandom_range(0, 3) == 0) || ($urandom_range(0, 99) == 0);
      cycle(rr, rdy, rv, rt);
    end

    // wrap-around instance
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    #1;
    chk("b_valid_after_rst", 32'(if_valid_b), 32'h0);
    chk("b_rom_addr_rst", rom_addr_b, RST_PC_B);
    @(posedge clk); #1;
    chk("b_pc0", if_pc_b, 32'hFFFF_FFF8);
    chk("b_instr0", if_instr_b, rom_word(32'hFFFF_FFF8));
    @(posedge clk); #1;
    chk("b_pc1", if_pc_b, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("b_pc2", if_pc_b, 32'h0000_0000);
    chk("b_instr2", if_instr_b, rom_word(32'h0));
    chk("b_valid", 32'(if_valid_b), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
